// File: rtl/trace_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_capture_pkg
// Description : Control-register map, FSM encoding and opcode constants
//               shared by the trace capture engine and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_capture_pkg;

    localparam logic [7:0] c_addr_start_en    = 8'h00;
    localparam logic [7:0] c_addr_end_en      = 8'h01;
    localparam logic [7:0] c_addr_start_addr  = 8'h02;
    localparam logic [7:0] c_addr_end_addr    = 8'h03;
    localparam logic [7:0] c_addr_wfi_stop_en = 8'h04;
    localparam logic [7:0] c_addr_range_mask  = 8'h05;
    localparam logic [7:0] c_addr_range_mode  = 8'h06;
    localparam logic [7:0] c_addr_rearm       = 8'h07;
    // Window i lower bound lives at base+2i, upper bound at base+2i+1.
    localparam logic [7:0] c_addr_range_base  = 8'h10;

    localparam logic [31:0] c_wfi_opcode = 32'h1050_0073;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_TRACING = 2'd2,
        ST_STOPPED = 2'd3
    } trace_state_t;

endpackage : trace_capture_pkg
`default_nettype wire

// File: rtl/trace_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_capture_fifo
// Description : Synchronous first-word-fall-through FIFO with occupancy
//               output. Writes into a full FIFO are refused even when a read
//               happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_capture_fifo
    import trace_capture_pkg::*;
#(
    parameter int WIDTH = 97,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_level = r_level;
    assign w_push  = i_wr_en & ~o_full;
    assign w_pop   = i_rd_en & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule : trace_capture_fifo
`default_nettype wire

// File: rtl/trace_capture_engine.sv
`default_nettype none
// ============================================================================
// Module      : trace_capture_engine
// Description : Filters the committed-instruction stream through NUM_RANGES
//               address windows under a start/end/WFI trigger FSM, buffers
//               captured {tlast, pc, instr} packets and streams them out on
//               an AXI4-Stream master.
//               Optional: define TRACE_CAPTURE_DROP_COUNT_EN to implement the
//               saturating drop counter (otherwise drop_count reads 0).
// Revision    : 1.0 - initial release
// ============================================================================
module trace_capture_engine
    import trace_capture_pkg::*;
#(
    parameter int XLEN                                = 64,
    parameter int NUM_RANGES                          = 4,
    parameter int FIFO_DEPTH                          = 16,
    parameter int CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED = 1,
    parameter int DATA_W                              = XLEN + 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          pc_valid,
    input  logic [XLEN-1:0]               pc,
    input  logic [31:0]                   instr,
    input  logic [7:0]                    ctrl_addr,
    input  logic [63:0]                   ctrl_wdata,
    input  logic                          ctrl_write_enable,
    input  logic [31:0]                   tlast_interval,
    output logic                          M_AXIS_tvalid,
    input  logic                          M_AXIS_tready,
    output logic [DATA_W-1:0]             M_AXIS_tdata,
    output logic                          M_AXIS_tlast,
    output logic [1:0]                    trace_state,
    output logic [31:0]                   drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    logic                  r_we_d;
    logic                  w_ctrl_wr;
    logic                  w_rearm;
    logic [XLEN-1:0]       w_wdata_x;

    logic                  r_start_en;
    logic                  r_end_en;
    logic                  r_wfi_stop_en;
    logic [XLEN-1:0]       r_start_addr;
    logic [XLEN-1:0]       r_end_addr;
    logic [NUM_RANGES-1:0] r_range_mask;
    logic                  r_range_mode;
    logic [XLEN-1:0]       r_lo [NUM_RANGES];
    logic [XLEN-1:0]       r_hi [NUM_RANGES];

    trace_state_t          r_state;
    logic [31:0]           r_pkt_cnt;

    logic [NUM_RANGES-1:0] w_win_hit;
    logic                  w_range_pass;
    logic                  w_start_hit;
    logic                  w_stop_hit;
    logic                  w_live;
    logic                  w_capture;
    logic                  w_periodic;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_W:0]       w_rd_data;
    logic                  w_unused;

    // ------------------------------------------------------------------
    // Control write strobe
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we_d <= 1'b0;
        end else begin
            r_we_d <= ctrl_write_enable;
        end
    end

    generate
        if (CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED != 0) begin : g_wr_posedge
            assign w_ctrl_wr = ctrl_write_enable & ~r_we_d;
        end else begin : g_wr_level
            assign w_ctrl_wr = ctrl_write_enable;
        end
    endgenerate

    assign w_rearm   = w_ctrl_wr & (ctrl_addr == c_addr_rearm);
    assign w_wdata_x = XLEN'(ctrl_wdata);

    // Fields narrower than the write bus simply discard the upper bits.
    assign w_unused = &{1'b0, ctrl_wdata, r_we_d};

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_en    <= 1'b0;
            r_end_en      <= 1'b0;
            r_wfi_stop_en <= 1'b1;
            r_start_addr  <= '0;
            r_end_addr    <= '1;
            r_range_mask  <= '0;
            r_range_mode  <= 1'b0;
            for (int i = 0; i < NUM_RANGES; i++) begin
                r_lo[i] <= '0;
                r_hi[i] <= '1;
            end
        end else if (w_ctrl_wr) begin
            case (ctrl_addr)
                c_addr_start_en:    r_start_en    <= ctrl_wdata[0];
                c_addr_end_en:      r_end_en      <= ctrl_wdata[0];
                c_addr_start_addr:  r_start_addr  <= w_wdata_x;
                c_addr_end_addr:    r_end_addr    <= w_wdata_x;
                c_addr_wfi_stop_en: r_wfi_stop_en <= ctrl_wdata[0];
                c_addr_range_mask:  r_range_mask  <= ctrl_wdata[NUM_RANGES-1:0];
                c_addr_range_mode:  r_range_mode  <= ctrl_wdata[0];
                default: ;
            endcase
            for (int i = 0; i < NUM_RANGES; i++) begin
                if (ctrl_addr == c_addr_range_base + 8'(2*i)) begin
                    r_lo[i] <= w_wdata_x;
                end
                if (ctrl_addr == c_addr_range_base + 8'(2*i + 1)) begin
                    r_hi[i] <= w_wdata_x;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Address windows: an inverted window (lo > hi) can never match
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NUM_RANGES; g++) begin : g_win
            assign w_win_hit[g] = r_range_mask[g] & (pc >= r_lo[g]) & (pc <= r_hi[g]);
        end
    endgenerate

    assign w_range_pass = (r_range_mask == '0) |
                          (r_range_mode ? ~(|w_win_hit) : (|w_win_hit));

    // ------------------------------------------------------------------
    // Triggers and capture qualification
    // ------------------------------------------------------------------
    assign w_start_hit = pc_valid & (pc == r_start_addr);
    assign w_stop_hit  = pc_valid & ((r_end_en & (pc == r_end_addr)) |
                                     (r_wfi_stop_en & (instr == c_wfi_opcode)));
    assign w_live      = (r_state == ST_TRACING) | ((r_state == ST_ARMED) & w_start_hit);
    assign w_capture   = pc_valid & en & w_range_pass & w_live;
    assign w_push      = w_capture & ~w_full;
    assign w_periodic  = (tlast_interval != 32'd0) & (r_pkt_cnt >= tlast_interval - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (!en) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    r_state <= r_start_en ? ST_ARMED : ST_TRACING;
                ST_ARMED: begin
                    if (w_start_hit) begin
                        r_state <= w_stop_hit ? ST_STOPPED : ST_TRACING;
                    end
                end
                ST_TRACING: begin
                    if (w_stop_hit) begin
                        r_state <= ST_STOPPED;
                    end
                end
                ST_STOPPED: begin
                    if (w_rearm) begin
                        r_state <= ST_IDLE;
                    end
                end
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    // Packet counter advances on accepted pushes only; rearm restarts the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt <= '0;
        end else if (w_rearm) begin
            r_pkt_cnt <= '0;
        end else if (w_push) begin
            r_pkt_cnt <= w_periodic ? 32'd0 : r_pkt_cnt + 32'd1;
        end
    end

`ifdef TRACE_CAPTURE_DROP_COUNT_EN
    logic [31:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_capture & w_full & (r_drop_count != 32'hFFFF_FFFF)) begin
            r_drop_count <= r_drop_count + 32'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = 32'd0;
`endif

    // ------------------------------------------------------------------
    // Packet buffer and stream output
    // ------------------------------------------------------------------
    trace_capture_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_capture),
        .i_wr_data ({(w_periodic | (w_live & w_stop_hit)), DATA_W'({pc, instr})}),
        .i_rd_en   (M_AXIS_tready),
        .o_rd_data (w_rd_data),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_level   (fifo_level)
    );

    assign M_AXIS_tvalid = ~w_empty;
    assign M_AXIS_tdata  = w_rd_data[DATA_W-1:0];
    assign M_AXIS_tlast  = w_rd_data[DATA_W];
    assign trace_state   = r_state;

endmodule : trace_capture_engine
`default_nettype wire
